// File: rtl/clint_pkg.sv
// Shared constants, state encoding and mstatus helpers for the core-local interrupt controller.
package clint_pkg;

  // Instruction encodings recognised in ID
  localparam logic [31:0] InstEcall  = 32'h0000_0073;
  localparam logic [31:0] InstEbreak = 32'h0010_0073;
  localparam logic [31:0] InstMret   = 32'h3020_0073;

  // mcause values
  localparam logic [31:0] CauseEcall  = 32'd11;
  localparam logic [31:0] CauseEbreak = 32'd3;
  localparam logic [31:0] CauseExtInt = 32'h8000_000B;

  // CSR addresses written through the CLINT port of csr_reg
  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;

  typedef enum logic [2:0] {
    StIdle,
    StWMepc,
    StWMstatus,
    StWMcause,
    StRetMstatus,
    StAssert
  } clint_state_e;

  // Trap entry: MPIE <- MIE, MIE <- 0
  function automatic logic [31:0] mstatus_trap(input logic [31:0] ms);
    logic [31:0] r;
    r    = ms;
    r[7] = ms[3];
    r[3] = 1'b0;
    return r;
  endfunction

  // Trap return: MIE <- MPIE, MPIE <- 1
  function automatic logic [31:0] mstatus_ret(input logic [31:0] ms);
    logic [31:0] r;
    r    = ms;
    r[3] = ms[7];
    r[7] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/clint.sv
// Core-local interrupt controller: detects traps/mret in ID, stalls the pipeline,
// sequences mepc/mstatus/mcause writes one per cycle, then issues a one-cycle redirect.
module clint
  import clint_pkg::*;
#(
  parameter int unsigned INT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      inst_addr_i,
  input  logic             jump_flag_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             hold_flag_i,
  input  logic [INT_W-1:0] int_flag_i,
  input  logic [31:0]      csr_mtvec_i,
  input  logic [31:0]      csr_mepc_i,
  input  logic [31:0]      csr_mstatus_i,
  input  logic             global_int_en_i,
  output logic             we_o,
  output logic [31:0]      waddr_o,
  output logic [31:0]      wdata_o,
  output logic             hold_flag_o,
  output logic             int_assert_o,
  output logic [31:0]      int_addr_o
);

  clint_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  cause_q, cause_d;
  logic         we_q, we_d;
  logic [31:0]  waddr_q, waddr_d;
  logic [31:0]  wdata_q, wdata_d;
  logic         assert_q, assert_d;
  logic [31:0]  addr_q, addr_d;

  logic ev_ecall, ev_ebreak, ev_mret, ev_int;

  // Event decode; an async interrupt waits while another unit holds the pipeline
  always_comb begin
    ev_ecall  = (inst_i == InstEcall);
    ev_ebreak = (inst_i == InstEbreak);
    ev_mret   = (inst_i == InstMret);
    ev_int    = (|int_flag_i) && global_int_en_i && !hold_flag_i;
  end

  // Next-state, latched PC/cause and stall request
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cause_d     = cause_q;
    hold_flag_o = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (ev_ecall) begin
          state_d     = StWMepc;
          pc_d        = inst_addr_i;
          cause_d     = CauseEcall;
          hold_flag_o = 1'b1;
        end else if (ev_ebreak) begin
          state_d     = StWMepc;
          pc_d        = inst_addr_i;
          cause_d     = CauseEbreak;
          hold_flag_o = 1'b1;
        end else if (ev_mret) begin
          state_d     = StRetMstatus;
          hold_flag_o = 1'b1;
        end else if (ev_int) begin
          state_d     = StWMepc;
          // A redirect in flight means inst_i is about to be squashed; resume at the target
          pc_d        = jump_flag_i ? jump_addr_i : inst_addr_i;
          cause_d     = CauseExtInt;
          hold_flag_o = 1'b1;
        end
      end
      StWMepc:      state_d = StWMstatus;
      StWMstatus:   state_d = StWMcause;
      StWMcause:    state_d = StAssert;
      StRetMstatus: state_d = StAssert;
      StAssert:     state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  // Registered outputs are precomputed from the state being entered
  always_comb begin
    we_d     = 1'b0;
    waddr_d  = 32'h0;
    wdata_d  = 32'h0;
    assert_d = 1'b0;
    addr_d   = 32'h0;
    unique case (state_d)
      StWMepc: begin
        we_d    = 1'b1;
        waddr_d = {20'h0, CsrMepc};
        wdata_d = pc_d;
      end
      StWMstatus: begin
        we_d    = 1'b1;
        waddr_d = {20'h0, CsrMstatus};
        wdata_d = mstatus_trap(csr_mstatus_i);
      end
      StWMcause: begin
        we_d    = 1'b1;
        waddr_d = {20'h0, CsrMcause};
        wdata_d = cause_d;
      end
      StRetMstatus: begin
        we_d    = 1'b1;
        waddr_d = {20'h0, CsrMstatus};
        wdata_d = mstatus_ret(csr_mstatus_i);
      end
      StAssert: begin
        assert_d = 1'b1;
        addr_d   = (state_q == StRetMstatus) ? csr_mepc_i : csr_mtvec_i;
      end
      default: begin
        we_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pc_q     <= 32'h0;
      cause_q  <= 32'h0;
      we_q     <= 1'b0;
      waddr_q  <= 32'h0;
      wdata_q  <= 32'h0;
      assert_q <= 1'b0;
      addr_q   <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cause_q  <= cause_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      assert_q <= assert_d;
      addr_q   <= addr_d;
    end
  end

  assign we_o         = we_q;
  assign waddr_o      = waddr_q;
  assign wdata_o      = wdata_q;
  assign int_assert_o = assert_q;
  assign int_addr_o   = addr_q;

endmodule

// File: tb/tb_clint.sv
// Scoreboard bench for clint: stimulus pushes expected CSR writes/redirects with their
// cycle stamps; a negedge monitor pops and compares whatever the DUT presents.
module tb_clint;

  localparam logic [31:0] Nop = 32'h0000_0013;
  localparam logic [31:0] Ecall = 32'h0000_0073;
  localparam logic [31:0] Mret = 32'h3020_0073;
  localparam logic [31:0] Mtvec = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst_i = Nop;
  logic [31:0] inst_addr_i = 32'h0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = 32'h0;
  logic        hold_flag_i = 1'b0;
  logic [7:0]  int_flag_i = 8'h0;
  logic [31:0] csr_mtvec = Mtvec;
  logic [31:0] csr_mepc = 32'h0;
  logic [31:0] csr_mstatus = 32'h0;
  logic        we_o, hold_flag_o, int_assert_o;
  logic [31:0] waddr_o, wdata_o, int_addr_o;

  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned cyc;
    bit          is_assert;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  clint #(.INT_W(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .inst_i          (inst_i),
    .inst_addr_i     (inst_addr_i),
    .jump_flag_i     (jump_flag_i),
    .jump_addr_i     (jump_addr_i),
    .hold_flag_i     (hold_flag_i),
    .int_flag_i      (int_flag_i),
    .csr_mtvec_i     (csr_mtvec),
    .csr_mepc_i      (csr_mepc),
    .csr_mstatus_i   (csr_mstatus),
    .global_int_en_i (csr_mstatus[3]),
    .we_o            (we_o),
    .waddr_o         (waddr_o),
    .wdata_o         (wdata_o),
    .hold_flag_o     (hold_flag_o),
    .int_assert_o    (int_assert_o),
    .int_addr_o      (int_addr_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int unsigned c, input bit a, input logic [31:0] ad,
                      input logic [31:0] d);
    exp_t e;
    e.cyc = c; e.is_assert = a; e.addr = ad; e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every output event must match the oldest expectation exactly
  always @(negedge clk) begin
    if (we_o || int_assert_o) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected @cyc %0d: we=%b addr=%h data=%h assert=%b iaddr=%h", cyc,
                 we_o, waddr_o, wdata_o, int_assert_o, int_addr_o);
      end else begin
        exp_t e;
        logic [31:0] ga, gd;
        e  = exp_q.pop_front();
        ga = int_assert_o ? 32'h0 : waddr_o;
        gd = int_assert_o ? int_addr_o : wdata_o;
        if (e.cyc != cyc || e.is_assert != int_assert_o || (we_o && int_assert_o) ||
            ga !== e.addr || gd !== e.data) begin
          n_fail++;
          $display("FAIL event @cyc %0d: assert=%b addr=%h data=%h expected cyc %0d assert=%b addr=%h data=%h",
                   cyc, int_assert_o, ga, gd, e.cyc, e.is_assert, e.addr, e.data);
        end
      end
    end
  end

  // One cycle; the bench's CSR model absorbs any write the DUT presented this cycle
  task automatic tick();
    logic        w;
    logic [31:0] a, d;
    w = we_o; a = waddr_o; d = wdata_o;
    @(posedge clk);
    #1;
    if (w && rst_n) begin
      if (a == 32'h300) csr_mstatus = d;
      if (a == 32'h341) csr_mepc = d;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_trap(input int unsigned k, input logic [31:0] pc,
                           input logic [31:0] ms_new, input logic [31:0] cause);
    push(k + 1, 1'b0, 32'h341, pc);
    push(k + 2, 1'b0, 32'h300, ms_new);
    push(k + 3, 1'b0, 32'h342, cause);
    push(k + 4, 1'b1, 32'h0, Mtvec);
  endtask

  initial begin
    int unsigned k;
    #1;
    ticks(2);
    chk("reset_we", {31'b0, we_o}, 32'h0);
    chk("reset_waddr", waddr_o, 32'h0);
    chk("reset_wdata", wdata_o, 32'h0);
    chk("reset_assert", {31'b0, int_assert_o}, 32'h0);
    chk("reset_iaddr", int_addr_o, 32'h0);
    chk("reset_hold", {31'b0, hold_flag_o}, 32'h0);
    rst_n = 1'b1;
    ticks(2);

    // ecall at 0x100, mstatus=0x8
    csr_mstatus = 32'h8; inst_addr_i = 32'h100; inst_i = Ecall;
    k = cyc;
    push_trap(k, 32'h100, 32'h80, 32'd11);
    #1 chk("ecall_hold_T", {31'b0, hold_flag_o}, 32'h1);
    tick(); inst_i = Nop;
    for (int i = 1; i <= 4; i++) begin
      #1 chk("ecall_hold_seq", {31'b0, hold_flag_o}, 32'h1);
      tick();
    end
    #1 chk("ecall_hold_idle", {31'b0, hold_flag_o}, 32'h0);
    ticks(2);

    // Interrupt during EX redirect: saved PC is the jump target
    csr_mstatus = 32'h8; int_flag_i = 8'h01; jump_flag_i = 1'b1; jump_addr_i = 32'h340;
    inst_addr_i = 32'h500;
    k = cyc;
    push_trap(k, 32'h340, 32'h80, 32'h8000_000B);
    tick(); int_flag_i = 8'h0; jump_flag_i = 1'b0;
    ticks(6);

    // Interrupt with MIE=0: nothing happens
    csr_mstatus = 32'h0; int_flag_i = 8'h01;
    for (int i = 0; i < 5; i++) begin
      #1 chk("mie0_hold", {31'b0, hold_flag_o}, 32'h0);
      tick();
    end
    int_flag_i = 8'h0;
    ticks(2);

    // mret with mepc=0x104, mstatus=0x80
    csr_mepc = 32'h104; csr_mstatus = 32'h80; inst_i = Mret;
    k = cyc;
    push(k + 1, 1'b0, 32'h300, 32'h88);
    push(k + 2, 1'b1, 32'h0, 32'h104);
    #1 chk("mret_hold_T", {31'b0, hold_flag_o}, 32'h1);
    tick(); inst_i = Nop;
    ticks(4);

    // Interrupt deferred by external hold for 3 cycles
    csr_mstatus = 32'h8; int_flag_i = 8'h04; hold_flag_i = 1'b1; inst_addr_i = 32'h600;
    for (int i = 0; i < 3; i++) begin
      #1 chk("held_int_hold", {31'b0, hold_flag_o}, 32'h0);
      tick();
    end
    hold_flag_i = 1'b0;
    k = cyc;
    push_trap(k, 32'h600, 32'h80, 32'h8000_000B);
    tick(); int_flag_i = 8'h0;
    ticks(6);

    // ecall is taken even while held
    csr_mstatus = 32'h0; hold_flag_i = 1'b1; inst_i = Ecall; inst_addr_i = 32'h650;
    k = cyc;
    push_trap(k, 32'h650, 32'h0, 32'd11);
    tick(); inst_i = Nop; hold_flag_i = 1'b0;
    ticks(6);

    // ecall beats a pending interrupt; interrupt stays masked until mret restores MIE
    csr_mstatus = 32'h8; int_flag_i = 8'h80; inst_i = Ecall; inst_addr_i = 32'h700;
    k = cyc;
    push_trap(k, 32'h700, 32'h80, 32'd11);
    tick(); inst_i = Nop; inst_addr_i = 32'h704;
    ticks(8);
    chk("masked_mstatus", csr_mstatus, 32'h80);
    inst_i = Mret;
    k = cyc;
    push(k + 1, 1'b0, 32'h300, 32'h88);
    push(k + 2, 1'b1, 32'h0, 32'h700);
    push_trap(k + 3, 32'h704, 32'h80, 32'h8000_000B);
    tick(); inst_i = Nop;
    ticks(3);
    int_flag_i = 8'h0;
    ticks(6);

    // Reset in the middle of a trap, then a clean ecall
    csr_mstatus = 32'h8; inst_i = Ecall; inst_addr_i = 32'h800;
    k = cyc;
    push(k + 1, 1'b0, 32'h341, 32'h800);
    tick(); inst_i = Nop;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_we", {31'b0, we_o}, 32'h0);
    chk("midrst_wdata", wdata_o, 32'h0);
    chk("midrst_hold", {31'b0, hold_flag_o}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_mstatus_kept", csr_mstatus, 32'h8);
    inst_i = Ecall; inst_addr_i = 32'h900;
    k = cyc;
    push_trap(k, 32'h900, 32'h80, 32'd11);
    tick(); inst_i = Nop;
    ticks(7);

    chk("queue_drained", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clint.md
# clint

Core-local interrupt/trap controller sitting beside `csr_reg` and driving its CLINT write port. Detects synchronous traps (ecall, ebreak), `mret`, and level-sensitive external interrupts at the ID stage. For each event it stalls the pipeline and sequences the required CSR updates (mepc, mstatus, mcause) one write per cycle. It then issues a one-cycle redirect to the trap vector or the return address.

## Interface
Parameters:
- `INT_W`, 8, width of external interrupt request vector.

Ports (reset `rst_n`, asynchronous, active-low; clock `clk`):
- `clk`  in  1  system clock.
- `rst_n`  in  1  async active-low reset.
- `inst_i`  in  32  instruction currently in ID.
- `inst_addr_i`  in  32  PC of `inst_i`.
- `jump_flag_i`  in  1  EX is redirecting this cycle.
- `jump_addr_i`  in  32  EX redirect target.
- `hold_flag_i`  in  1  pipeline stalled by another source (e.g. multicycle divide).
- `int_flag_i`  in  INT_W  external interrupt requests, level, any bit set = pending.
- `csr_mtvec_i`  in  32  current mtvec.
- `csr_mepc_i`  in  32  current mepc.
- `csr_mstatus_i`  in  32  current mstatus.
- `global_int_en_i`  in  1  mstatus.MIE.
- `we_o`  out  1  CSR write enable to `csr_reg` CLINT port.
- `waddr_o`  out  32  CSR write address, upper 20 bits zero.
- `wdata_o`  out  32  CSR write data.
- `hold_flag_o`  out  1  stall request to pipeline control.
- `int_assert_o`  out  1  one-cycle redirect strobe to EX/PC.
- `int_addr_o`  out  32  redirect target, valid while `int_assert_o`.

## Operation
- States: IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, RET_MSTATUS, ASSERT.
- Event detection occurs only in IDLE. Priority is highest first:
  - `inst_i`==32'h00000073 (ecall): sync trap, cause 32'd11.
  - `inst_i`==32'h00100073 (ebreak): sync trap, cause 32'd3.
  - `inst_i`==32'h30200073 (mret): return.
  - `|int_flag_i` && `global_int_en_i` && !`hold_flag_i`: async trap, cause 32'h8000000B.
- Sync and mret are accepted regardless of `hold_flag_i`. An async trap is deferred while `hold_flag_i`=1.
- Saved PC is latched at detection:
  - sync trap: `inst_addr_i`.
  - async trap: `jump_addr_i` if `jump_flag_i`, else `inst_addr_i`.
- Cause is latched at detection.
- Trap path: IDLE→W_MEPC→W_MSTATUS→W_MCAUSE→ASSERT→IDLE.
  - W_MEPC: we=1, waddr=0x341, wdata=saved PC.
  - W_MSTATUS: we=1, waddr=0x300, wdata=`csr_mstatus_i` with bit7 (MPIE) set to `csr_mstatus_i[3]` and bit3 (MIE) set to 0.
  - W_MCAUSE: we=1, waddr=0x342, wdata=latched cause.
  - ASSERT: `int_assert_o`=1, `int_addr_o`=`csr_mtvec_i`.
- Return path: IDLE→RET_MSTATUS→ASSERT→IDLE.
  - RET_MSTATUS: we=1, waddr=0x300, wdata=`csr_mstatus_i` with bit3 set to `csr_mstatus_i[7]` and bit7 set to 1.
  - ASSERT: `int_addr_o`=`csr_mepc_i`.
- `int_flag_i` changes outside IDLE are ignored. A request still held high after the trap is not retaken while MIE=0; it is retaken after `mret` restores MIE.
- Unknown instructions: no action.
- No register writes happen in ASSERT or IDLE.
- `hold_flag_o` keeps EX from issuing CSR writes during a sequence. `csr_reg` gives priority to EX writes, so such a write would collide.

## Timing
- Reset: state IDLE; `we_o`, `waddr_o`, `wdata_o`, `int_assert_o`, `int_addr_o`, `hold_flag_o` all 0; latched PC and cause 0.
- `we_o`, `waddr_o`, `wdata_o`, `int_assert_o`, `int_addr_o` are registered.
- `hold_flag_o` is combinational. It is 1 in the IDLE detection cycle whenever an event is accepted, and 1 in every non-IDLE state including ASSERT.
- Trap latency: detect at cycle T; mepc write in T+1, mstatus T+2, mcause T+3, `int_assert_o` in T+4; IDLE at T+5.
- mret latency: detect at T; mstatus write T+1; `int_assert_o` T+2.
- Back-to-back events: a new event can be detected in the first IDLE cycle after ASSERT.
- Reset asserted mid-sequence: immediate return to IDLE with all outputs 0. Partial CSR updates already written are not undone.
- `int_assert_o` is exactly one cycle wide.

## Structure
- Constants go in `defines.v` alongside the existing `CSR_*` addresses:
  - instruction encodings INST_ECALL, INST_EBREAK, INST_MRET;
  - cause codes;
  - state encodings (one-hot or 3-bit binary, implementer's choice).
- No sub-module. It is a single FSM with datapath latches.

## Test plan
- ecall at PC 0x100, mtvec=0x200, mstatus=0x8: writes 0x341←0x100, 0x300←0x80, 0x342←11 on T+1..T+3; `int_assert_o`=1 with addr 0x200 at T+4; `hold_flag_o`=1 from T to T+4.
- `int_flag_i`=0x01, MIE=1, `jump_flag_i`=1 with `jump_addr_i`=0x340: mepc←0x340, mcause←0x8000000B. Repeat with MIE=0: no activity.
- mret with mepc=0x104, mstatus=0x80: 0x300←0x88 at T+1; assert with addr 0x104 at T+2.
- Interrupt pending with `hold_flag_i`=1 for 3 cycles: no `we_o` until the cycle after hold drops; detection then proceeds as normal. ecall with `hold_flag_i`=1 is taken immediately.
- ecall and interrupt pending simultaneously: cause 11 is written. The interrupt, held high, is not retaken until after `mret`.
- `rst_n` pulsed low at T+2 of a trap: all outputs 0 and IDLE at once; the next ecall runs the full sequence.
